// File: rtl/ecall_controller.sv
// ecall_controller: sequences environment-call services (print, read, test-case
// load, exit) for the single-cycle core, stalls the PC while a service runs and
// shares the register file write port between core writeback and a0 writes.
module ecall_controller #(
  parameter int DATA_W       = 32,
  parameter int PRINT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ecall,
  input  logic [DATA_W-1:0] a7_value,
  input  logic [DATA_W-1:0] a0_value,
  input  logic [DATA_W-1:0] io_input,
  input  logic              confirm,
  input  logic [DATA_W-1:0] test_case,
  input  logic              core_we,
  input  logic [4:0]        core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              io_out_valid,
  output logic [DATA_W-1:0] io_out_data,
  output logic [7:0]        led_out,
  output logic              halted
);

  localparam int                CNT_W    = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRINT_CYCLES - 1);
  localparam logic [4:0]        A0_ADDR  = 5'd10;

  typedef enum logic [2:0] {
    IDLE,
    PRINT,
    READ_WAIT,
    READ_WB,
    TC_WB,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              confirm_prev_q, confirm_prev_d;

  logic              svc_print, svc_read, svc_exit, svc_tc, svc_known;
  logic              confirm_rise;

  // Service decode of a7 and confirm edge detection
  always_comb begin
    svc_print    = (a7_value == DATA_W'(1));
    svc_read     = (a7_value == DATA_W'(5));
    svc_exit     = (a7_value == DATA_W'(10));
    svc_tc       = (a7_value == DATA_W'(11));
    svc_known    = svc_print | svc_read | svc_exit | svc_tc;
    confirm_rise = confirm & ~confirm_prev_q;
  end

  // State register plus service counter, data latch, display latch and confirm history
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      data_q         <= '0;
      out_q          <= '0;
      confirm_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      out_q          <= out_d;
      confirm_prev_q <= confirm_prev_d;
    end
  end

  // Next-state logic; unknown a7 values leave the controller idle
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    out_d          = out_q;
    confirm_prev_d = confirm;
    case (state_q)
      IDLE: begin
        if (ecall) begin
          if (svc_print) begin
            state_d = PRINT;
            out_d   = a0_value;
            cnt_d   = CNT_LAST;
          end else if (svc_read) begin
            state_d = READ_WAIT;
          end else if (svc_exit) begin
            state_d = HALT;
          end else if (svc_tc) begin
            state_d = TC_WB;
            data_d  = test_case;
          end
        end
      end
      PRINT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ_WAIT: begin
        // Only a fresh press counts; a level held from before entry is ignored
        if (confirm_rise) begin
          data_d  = io_input;
          state_d = READ_WB;
        end
      end
      READ_WB, TC_WB: begin
        state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; stall drops on the finishing cycle so the PC steps past the ecall exactly once
  always_comb begin
    stall        = 1'b0;
    io_out_valid = 1'b0;
    led_out      = 8'h00;
    halted       = 1'b0;
    rf_we        = core_we && (core_rd != 5'd0);
    rf_waddr     = core_rd;
    rf_wdata     = core_wdata;
    case (state_q)
      IDLE: begin
        stall = ecall && svc_known;
      end
      PRINT: begin
        io_out_valid = 1'b1;
        stall        = (cnt_q != '0);
      end
      READ_WAIT: begin
        stall      = 1'b1;
        led_out[7] = 1'b1;
      end
      READ_WB: begin
        rf_we    = 1'b1;
        rf_waddr = A0_ADDR;
        rf_wdata = data_q;
      end
      TC_WB: begin
        rf_we      = 1'b1;
        rf_waddr   = A0_ADDR;
        rf_wdata   = data_q;
        led_out[1] = 1'b1;
      end
      HALT: begin
        halted     = 1'b1;
        led_out[0] = 1'b1;
        stall      = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign io_out_data = out_q;

endmodule

// File: tb/tb_ecall_controller.sv
// Bench for ecall_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a service-level model.
module tb_ecall_controller;

  localparam int DW = 32;
  localparam int PC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ecall;
  logic [DW-1:0] a7_value, a0_value, io_input, test_case, core_wdata;
  logic          confirm, core_we;
  logic [4:0]    core_rd;
  logic          rf_we, stall, io_out_valid, halted;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata, io_out_data;
  logic [7:0]    led_out;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Service-level model state
  bit          m_halt;
  int          m_print_left;
  bit          m_read_wait;
  bit          m_wb;
  bit          m_wb_tc;
  logic [DW-1:0] m_wb_val;
  logic [DW-1:0] m_disp;
  bit          m_cprev;

  always #5 clk = ~clk;

  ecall_controller #(.DATA_W(DW), .PRINT_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .ecall(ecall), .a7_value(a7_value),
    .a0_value(a0_value), .io_input(io_input), .confirm(confirm),
    .test_case(test_case), .core_we(core_we), .core_rd(core_rd),
    .core_wdata(core_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall(stall), .io_out_valid(io_out_valid),
    .io_out_data(io_out_data), .led_out(led_out), .halted(halted)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model to the next edge
  always @(negedge clk) begin
    bit known, e_stall, e_we;
    logic [4:0] e_addr;
    logic [DW-1:0] e_data;
    #2;
    known = (a7_value == 1) || (a7_value == 5) || (a7_value == 10) || (a7_value == 11);
    if (m_halt)                e_stall = 1'b1;
    else if (m_print_left > 0) e_stall = (m_print_left > 1);
    else if (m_read_wait)      e_stall = 1'b1;
    else if (m_wb)             e_stall = 1'b0;
    else                       e_stall = ecall && known;
    if (m_wb) begin
      e_we = 1'b1; e_addr = 5'd10; e_data = m_wb_val;
    end else begin
      e_we = core_we && (core_rd != 0); e_addr = core_rd; e_data = core_wdata;
    end
    if (chk_en) begin
      check("m_stall", {31'd0, stall}, {31'd0, e_stall});
      check("m_valid", {31'd0, io_out_valid}, {31'd0, (m_print_left > 0)});
      check("m_halted", {31'd0, halted}, {31'd0, m_halt});
      check("m_led", {24'd0, led_out}, {24'd0, m_read_wait, 5'd0, (m_wb && m_wb_tc), m_halt});
      check("m_out_data", io_out_data, m_disp);
      check("m_rf_we", {31'd0, rf_we}, {31'd0, e_we});
      check("m_rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
      check("m_rf_wdata", rf_wdata, e_data);
    end
    if (!reset) begin
      m_halt = 0; m_print_left = 0; m_read_wait = 0; m_wb = 0; m_wb_tc = 0;
      m_wb_val = '0; m_disp = '0; m_cprev = 0;
      chk_en = 1'b1;
    end else begin
      if (m_halt) begin
        m_halt = 1'b1;
      end else if (m_print_left > 0) begin
        m_print_left--;
      end else if (m_read_wait) begin
        if (confirm && !m_cprev) begin
          m_read_wait = 0; m_wb = 1; m_wb_tc = 0; m_wb_val = io_input;
        end
      end else if (m_wb) begin
        m_wb = 0;
      end else if (ecall) begin
        if (a7_value == 1) begin
          m_print_left = PC; m_disp = a0_value;
        end else if (a7_value == 5) begin
          m_read_wait = 1;
        end else if (a7_value == 10) begin
          m_halt = 1;
        end else if (a7_value == 11) begin
          m_wb = 1; m_wb_tc = 1; m_wb_val = test_case;
        end
      end
      m_cprev = confirm;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int nv, ns, sel;
    reset = 0; ecall = 1; a7_value = 1; a0_value = 32'h55; io_input = 0;
    confirm = 0; test_case = 0; core_we = 0; core_rd = 0; core_wdata = 0;

    // Reset held with a print request pending
    tick(); tick(); #3;
    check("rst_valid", {31'd0, io_out_valid}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_led", {24'd0, led_out}, 0);
    check("rst_out_data", io_out_data, 0);
    check("rst_rf_we", {31'd0, rf_we}, 0);

    // Print of 0x2A: PC valid cycles, PC stalled cycles including detect
    tick(); reset = 1; ecall = 1; a7_value = 1; a0_value = 32'h2A; #3;
    check("print_detect_stall", {31'd0, stall}, 1);
    nv = 0; ns = 1;
    for (int i = 0; i < 8; i++) begin
      tick(); ecall = 0; a0_value = 32'h99; #3;
      nv += int'(io_out_valid); ns += int'(stall);
    end
    check("print_valid_cycles", nv, PC);
    check("print_stall_cycles", ns, PC);
    check("print_data_kept", io_out_data, 32'h2A);

    // Read with confirm already high at entry
    tick(); confirm = 1; ecall = 1; a7_value = 5; #3;
    check("read_detect_stall", {31'd0, stall}, 1);
    repeat (3) begin
      tick(); ecall = 0; #3;
      check("read_wait_led", {24'd0, led_out}, 32'h80);
      check("read_wait_rf_we", {31'd0, rf_we}, 0);
    end
    tick(); confirm = 0; io_input = 32'h1234; #3;
    check("read_wait_stall", {31'd0, stall}, 1);
    tick(); confirm = 1; #3;
    check("read_edge_stall", {31'd0, stall}, 1);
    tick(); #3;
    check("read_wb_we", {31'd0, rf_we}, 1);
    check("read_wb_addr", {27'd0, rf_waddr}, 10);
    check("read_wb_data", rf_wdata, 32'h1234);
    check("read_wb_stall", {31'd0, stall}, 0);
    tick(); confirm = 0; #3;
    check("read_done_led", {24'd0, led_out}, 0);

    // Test-case load overrides a concurrent core write
    tick(); ecall = 1; a7_value = 11; test_case = 7; #3;
    check("tc_detect_stall", {31'd0, stall}, 1);
    tick(); ecall = 0; core_we = 1; core_rd = 3; core_wdata = 32'hFFFF; #3;
    check("tc_wb_we", {31'd0, rf_we}, 1);
    check("tc_wb_addr", {27'd0, rf_waddr}, 10);
    check("tc_wb_data", rf_wdata, 7);
    check("tc_wb_led", {24'd0, led_out}, 2);
    check("tc_wb_stall", {31'd0, stall}, 0);

    // Core passthrough, x0 suppression, unknown service no-op
    tick(); core_rd = 5; core_wdata = 32'hDEAD; #3;
    check("pass_we", {31'd0, rf_we}, 1);
    check("pass_addr", {27'd0, rf_waddr}, 5);
    check("pass_data", rf_wdata, 32'hDEAD);
    tick(); core_rd = 0; #3;
    check("pass_x0_we", {31'd0, rf_we}, 0);
    tick(); core_we = 0; ecall = 1; a7_value = 3; #3;
    check("noop_stall", {31'd0, stall}, 0);
    tick(); ecall = 0; #3;
    check("noop_valid", {31'd0, io_out_valid}, 0);
    check("noop_led", {24'd0, led_out}, 0);

    // Exit is terminal until reset
    tick(); ecall = 1; a7_value = 10; #3;
    check("exit_detect_stall", {31'd0, stall}, 1);
    tick(); a7_value = 1; #3;
    check("halt_halted", {31'd0, halted}, 1);
    check("halt_led", {24'd0, led_out}, 1);
    check("halt_stall", {31'd0, stall}, 1);
    repeat (3) begin
      tick(); confirm = ~confirm; #3;
      check("halt_no_print", {31'd0, io_out_valid}, 0);
      check("halt_stays", {31'd0, halted}, 1);
    end
    tick(); reset = 0; ecall = 0; confirm = 0;
    tick(); reset = 1; #3;
    check("halt_cleared", {31'd0, halted}, 0);
    check("halt_cleared_led", {24'd0, led_out}, 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 79) != 0);
      ecall = ($urandom_range(0, 2) == 0);
      sel = int'($urandom_range(0, 31));
      if (sel < 8)       a7_value = 1;
      else if (sel < 13) a7_value = 5;
      else if (sel < 18) a7_value = 11;
      else if (sel < 19) a7_value = 10;
      else if (sel < 28) a7_value = $urandom_range(0, 15);
      else               a7_value = $urandom;
      a0_value   = $urandom;
      io_input   = $urandom;
      test_case  = $urandom;
      if ($urandom_range(0, 3) == 0) confirm = ~confirm;
      core_we    = $urandom_range(0, 1);
      core_rd    = 5'($urandom_range(0, 31));
      core_wdata = $urandom;
    end
    tick();
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecall_controller.md
Name: ecall_controller

Overview:
- Sequences environment-call services for the single-cycle core.
- Decodes a7 when the core raises an ecall, stalls the PC for the service duration, and handles the IO handshakes (print, keyboard/switch read, test-case load, exit).
- Arbitrates the register file's single write port between core writeback and service writes to a0 (x10).
- Sits between the decoder/PC logic and the register file.

Parameters:
- DATA_W, 32, width of register data, io_input, test_case and io_out_data.
- PRINT_CYCLES, 16, number of cycles io_out_valid is held per print service. Legal range is ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- ecall  input  1  high while the current instruction is ecall.
- a7_value  input  DATA_W  current contents of x17.
- a0_value  input  DATA_W  current contents of x10.
- io_input  input  DATA_W  switch/keyboard input value.
- confirm  input  1  debounced confirm button (level).
- test_case  input  DATA_W  selected test-case number.
- core_we  input  1  core writeback enable.
- core_rd  input  5  core destination register.
- core_wdata  input  DATA_W  core writeback data.
- rf_we  output  1  register file write enable.
- rf_waddr  output  5  register file write address.
- rf_wdata  output  DATA_W  register file write data.
- stall  output  1  freeze PC/instruction fetch when high.
- io_out_valid  output  1  display-update strobe (print service).
- io_out_data  output  DATA_W  value to display.
- led_out  output  8  status LEDs.
- halted  output  1  exit service reached.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; counter=0; data latch=0; confirm_prev=0.
  - io_out_data=0, io_out_valid=0, led_out=0, halted=0.
  - Reset mid-service aborts the service immediately. No a0 write occurs.
- States: IDLE, PRINT, READ_WAIT, READ_WB, TC_WB, HALT.
- IDLE transitions, on ecall=1:
  - a7==1 -> PRINT; latch a0_value into io_out_data; counter=PRINT_CYCLES-1.
  - a7==5 -> READ_WAIT.
  - a7==10 -> HALT.
  - a7==11 -> TC_WB; latch test_case into data latch.
  - Any other a7 -> remain IDLE. This is a no-op with stall=0.
- PRINT:
  - io_out_valid=1 each cycle.
  - Counter decrements each cycle; when counter==0 -> IDLE.
  - io_out_data holds its value after PRINT until the next print service.
- READ_WAIT:
  - led_out[7]=1.
  - confirm rising edge (confirm & ~confirm_prev) -> latch io_input into data latch, then READ_WB.
  - A level held high from before entry does not count as an edge.
- READ_WB / TC_WB (one cycle each):
  - rf_we=1, rf_waddr=10, rf_wdata=data latch -> IDLE.
  - led_out[1]=1 during TC_WB only.
- HALT:
  - Terminal until reset.
  - halted=1, led_out[0]=1, stall=1.
  - ecall and confirm are ignored.
- stall is combinational:
  - In IDLE: 1 when ecall and a7∈{1,5,10,11}, else 0.
  - In READ_WAIT: 1.
  - In PRINT: 1 except in the last cycle (counter==0).
  - In READ_WB and TC_WB: 0.
  - In HALT: 1.
  - Effect: the PC advances past the ecall on the edge that finishes the service, so the same ecall is never retriggered.
- Write port arbitration:
  - In READ_WB/TC_WB the service write wins.
  - Core writeback is guaranteed idle there because the core is stalled on the ecall, which has no writeback.
  - Otherwise rf_we = core_we && core_rd!=0, rf_waddr=core_rd, rf_wdata=core_wdata.
  - Service writes never target x0.
- Latency:
  - print = PRINT_CYCLES cycles of stall, including the ecall-detect cycle.
  - test-case = 1 stalled cycle, with the write on the next edge.
  - read = unbounded, until confirm; the write occurs 1 cycle after the edge.
- Unused led_out bits [6:2] are 0.
- confirm_prev updates every cycle in all states.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with ecall=1, a7=1 -> all outputs 0, state IDLE. Release reset -> print starts next edge.
- Print, PRINT_CYCLES=4: a0=0x0000_002A, ecall pulse in IDLE.
  - io_out_valid high exactly 4 cycles; stall high 4 cycles, low in the last.
  - io_out_data=0x2A and retained after completion.
- Read: a7=5 with confirm already high at entry -> stays in READ_WAIT with led_out[7]=1. Drop confirm, set io_input=0x1234, raise confirm -> next cycle rf_we=1, rf_waddr=10, rf_wdata=0x1234; stall low that cycle.
- Test case: a7=11, test_case=7 -> one cycle later rf_we=1, addr 10, data 7, led_out[1]=1. Core writes during that cycle are suppressed.
- Exit: a7=10 -> halted=1, led_out[0]=1, stall stuck high. Subsequent ecall a7=1 gives no io_out_valid. reset=0 clears halted.
- Passthrough and no-op:
  - core_we=1, rd=5, data=0xDEAD in IDLE -> rf write to x5.
  - rd=0 -> rf_we=0.
  - ecall with a7=3 -> stall=0, no state change.
